// File: rtl/key_debounce_pkg.sv
// Shared definitions for the key input path: debounce FSM states and the
// default timing constants for a 100 MHz system clock.
package key_pkg;

    typedef enum logic [1:0] {
        LOW      = 2'd0,
        RISE_CHK = 2'd1,
        HIGH     = 2'd2,
        FALL_CHK = 2'd3
    } key_state_t;

    localparam int unsigned DEB_10MS_100MHZ   = 1_000_000;
    localparam int unsigned HOLD_500MS_100MHZ = 50_000_000;

endpackage

// File: rtl/key_debounce_sync_2ff.sv
// Two-flop synchroniser for asynchronous pad inputs; both stages reset to 0.
module sync_2ff (
    input  logic clk,
    input  logic rstn,
    input  logic d,
    output logic q
);

    logic [1:0] stage_reg;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            stage_reg <= '0;
        end else begin
            stage_reg <= {stage_reg[0], d};
        end
    end

    assign q = stage_reg[1];

endmodule

// File: rtl/key_debounce.sv
// Push-button conditioner: synchronise, debounce to a stable level on out,
// and raise hold once out has stayed high long enough.
module key_debounce
    import key_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEB_10MS_100MHZ,
    parameter int unsigned HOLD_CYCLES     = HOLD_500MS_100MHZ,
    parameter bit          ACTIVE_LOW      = 1'b0
) (
    input  logic clk,
    input  logic rstn,
    input  logic in,
    output logic out,
    output logic hold
);

    localparam int CNT_W  = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(HOLD_CYCLES);

    logic              lvl;
    logic              s;
    logic              fall_now;
    key_state_t        state_reg;
    logic [CNT_W-1:0]  cnt_reg;
    logic [HOLD_W-1:0] hold_cnt_reg;
    logic              out_reg;
    logic              hold_reg;

    assign lvl = in ^ ACTIVE_LOW;

    sync_2ff u_sync (
        .clk  (clk),
        .rstn (rstn),
        .d    (lvl),
        .q    (s)
    );

    // The edge on which out drops is also the edge that clears the hold logic.
    assign fall_now = (state_reg == FALL_CHK) && !s && (cnt_reg == CNT_LAST);

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_reg    <= LOW;
            cnt_reg      <= '0;
            hold_cnt_reg <= '0;
            out_reg      <= 1'b0;
            hold_reg     <= 1'b0;
        end else begin
            case (state_reg)
                LOW: begin
                    if (s) begin
                        state_reg <= RISE_CHK;
                        cnt_reg   <= '0;
                    end
                end
                RISE_CHK: begin
                    if (!s) begin
                        state_reg <= LOW;
                        cnt_reg   <= '0;
                    end else if (cnt_reg == CNT_LAST) begin
                        state_reg <= HIGH;
                        out_reg   <= 1'b1;
                        cnt_reg   <= '0;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                HIGH: begin
                    if (!s) begin
                        state_reg <= FALL_CHK;
                        cnt_reg   <= '0;
                    end
                end
                FALL_CHK: begin
                    if (s) begin
                        state_reg <= HIGH;
                        cnt_reg   <= '0;
                    end else if (cnt_reg == CNT_LAST) begin
                        state_reg <= LOW;
                        out_reg   <= 1'b0;
                        cnt_reg   <= '0;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                default: begin
                    state_reg <= LOW;
                    cnt_reg   <= '0;
                end
            endcase

            // A bounce back from FALL_CHK keeps out high, so hold survives it.
            if (fall_now) begin
                hold_cnt_reg <= '0;
                hold_reg     <= 1'b0;
            end else if (out_reg) begin
                if (hold_cnt_reg != HOLD_MAX) begin
                    hold_cnt_reg <= hold_cnt_reg + 1'b1;
                end
                if (hold_cnt_reg == HOLD_LAST) begin
                    hold_reg <= 1'b1;
                end
            end
        end
    end

    assign out  = out_reg;
    assign hold = hold_reg;

endmodule

// File: tb/tb_key_debounce.sv
// Randomised and directed bench for key_debounce against a run-length
// reference model of the debounced level and hold time.
module tb_key_debounce;

    localparam int D = 4;
    localparam int H = 16;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    logic key_in = 1'b0;
    logic key_out;
    logic key_hold;

    always #5 clk = ~clk;

    key_debounce #(
        .DEBOUNCE_CYCLES (D),
        .HOLD_CYCLES     (H),
        .ACTIVE_LOW      (1'b0)
    ) dut (
        .clk  (clk),
        .rstn (rstn),
        .in   (key_in),
        .out  (key_out),
        .hold (key_hold)
    );

    int checks = 0;
    int errors = 0;

    // reference model: pad delayed two edges, level accepted after D+1
    // consecutive disagreeing samples, hold after H edges of out high
    logic m_pipe1 = 1'b0, m_pipe2 = 1'b0;
    logic m_out = 1'b0, m_hold = 1'b0;
    int   disagree = 0;
    int   high_len = 0;

    int   edge_no = 0;
    int   rise_edge = -1, fall_edge = -1;
    int   hold_rise_edge = -1, hold_fall_edge = -1;
    int   rise_count = 0, fall_count = 0;
    logic out_prev = 1'b0, hold_prev = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d expected=%0d", tag, $signed(got), $signed(exp));
        end
    endtask

    task automatic tick(input logic in_v, input logic rstn_v);
        logic s_now, pre_out;
        key_in = in_v;
        rstn   = rstn_v;
        @(posedge clk);
        edge_no++;
        if (!rstn_v) begin
            m_pipe1 = 1'b0; m_pipe2 = 1'b0;
            m_out = 1'b0; m_hold = 1'b0;
            disagree = 0; high_len = 0;
        end else begin
            s_now   = m_pipe2;
            m_pipe2 = m_pipe1;
            m_pipe1 = in_v;
            pre_out = m_out;
            disagree = (s_now != m_out) ? disagree + 1 : 0;
            if (disagree == D + 1) begin
                m_out = s_now;
                disagree = 0;
            end
            if (pre_out && !m_out) begin
                high_len = 0;
                m_hold = 1'b0;
            end else if (pre_out) begin
                high_len++;
                if (high_len >= H) m_hold = 1'b1;
            end
        end
        #1;
        check("out", 32'(key_out), 32'(m_out));
        check("hold", 32'(key_hold), 32'(m_hold));
        if (key_out === 1'b1 && out_prev === 1'b0) begin rise_edge = edge_no; rise_count++; end
        if (key_out === 1'b0 && out_prev === 1'b1) begin fall_edge = edge_no; fall_count++; end
        if (key_hold === 1'b1 && hold_prev === 1'b0) hold_rise_edge = edge_no;
        if (key_hold === 1'b0 && hold_prev === 1'b1) hold_fall_edge = edge_no;
        out_prev  = key_out;
        hold_prev = key_hold;
        $display("edge %0d rstn=%b in=%b out=%b hold=%b", edge_no, rstn_v, in_v, key_out, key_hold);
    endtask

    task automatic run(input logic in_v, input int n);
        for (int i = 0; i < n; i++) tick(in_v, 1'b1);
    endtask

    initial begin
        int e0, rc0, fc0, n;

        // 1: reset with pad high, then release
        for (int i = 0; i < 3; i++) begin
            tick(1'b1, 1'b0);
            check("rst_out", 32'(key_out), 32'd0);
            check("rst_hold", 32'(key_hold), 32'd0);
        end
        e0 = edge_no + 1;
        rise_edge = -1;
        run(1'b1, 10);
        check("rst_release_lat", 32'(rise_edge - e0), 32'd6);
        run(1'b0, 25);

        // 2: clean press and release
        rc0 = rise_count; fc0 = fall_count;
        e0 = edge_no + 1; rise_edge = -1;
        run(1'b1, 20);
        check("press_lat", 32'(rise_edge - e0), 32'd6);
        e0 = edge_no + 1; fall_edge = -1;
        run(1'b0, 12);
        check("release_lat", 32'(fall_edge - e0), 32'd6);
        check("one_rise", 32'(rise_count - rc0), 32'd1);
        check("one_fall", 32'(fall_count - fc0), 32'd1);

        // 3: bounce on press, then isolated short pulses
        rc0 = rise_count;
        run(1'b1, 3);
        run(1'b0, 1);
        check("glitch_low", 32'(key_out), 32'd0);
        e0 = edge_no + 1; rise_edge = -1;
        run(1'b1, 10);
        check("bounce_lat", 32'(rise_edge - e0), 32'd6);
        check("bounce_one_rise", 32'(rise_count - rc0), 32'd1);
        run(1'b0, 12);
        rc0 = rise_count;
        for (int k = 1; k <= 3; k++) begin
            run(1'b1, k);
            run(1'b0, 10);
        end
        check("short_pulses", 32'(rise_count - rc0), 32'd0);

        // 4: long hold, dropout while held, release
        rise_edge = -1; hold_rise_edge = -1;
        run(1'b1, 40);
        check("hold_lat", 32'(hold_rise_edge - rise_edge), 32'd16);
        run(1'b0, 2);
        run(1'b1, 6);
        check("hold_dropout", 32'(key_hold), 32'd1);
        e0 = edge_no + 1; fall_edge = -1; hold_fall_edge = -1;
        run(1'b0, 12);
        check("hold_rel_out", 32'(fall_edge - e0), 32'd6);
        check("hold_rel_hold", 32'(hold_fall_edge - e0), 32'd6);

        // 5: reset mid-count in RISE_CHK, then in FALL_CHK with hold set
        run(1'b1, 5);
        tick(1'b1, 1'b0);
        check("midrst_out", 32'(key_out), 32'd0);
        e0 = edge_no + 1; rise_edge = -1;
        run(1'b1, 10);
        check("midrst_restart", 32'(rise_edge - e0), 32'd6);
        run(1'b1, 20);
        check("pre_rst_hold", 32'(key_hold), 32'd1);
        run(1'b0, 4);
        tick(1'b0, 1'b0);
        check("fallrst_out", 32'(key_out), 32'd0);
        check("fallrst_hold", 32'(key_hold), 32'd0);
        run(1'b0, 10);

        // 6: bouncy presses feeding a rising-edge pulse detector
        rc0 = rise_count;
        for (int p = 0; p < 5; p++) begin
            n = $urandom_range(1, 4);
            for (int g = 0; g < n; g++) begin
                run(1'b1, $urandom_range(1, 3));
                run(1'b0, $urandom_range(1, 3));
            end
            run(1'b1, 12);
            n = $urandom_range(1, 4);
            for (int g = 0; g < n; g++) begin
                run(1'b0, $urandom_range(1, 3));
                run(1'b1, $urandom_range(1, 3));
            end
            run(1'b0, 12);
        end
        check("pulse_count", 32'(rise_count - rc0), 32'd5);

        // random runs with occasional resets
        for (int seg = 0; seg < 300; seg++) begin
            if ($urandom_range(0, 39) == 0) begin
                tick(1'($urandom_range(0, 1)), 1'b0);
            end else begin
                run(1'($urandom_range(0, 1)), $urandom_range(1, 8));
            end
        end
        run(1'b1, 30);
        run(1'b0, 12);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
